// File: rtl/vme_cmd_pkg.sv
// vme_cmd_pkg: FSM states and command-word constants shared by the VME command sequencer.
package vme_cmd_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    localparam logic [31:0] CMD_MASK     = 32'h00A80000;
    localparam int          RD_BIT       = 25;
    localparam int          WR_BIT       = 24;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
endpackage

// File: rtl/vme_cmd_sequencer_arb.sv
// rr_arbiter: combinational round-robin pick; priority starts at ptr_i and wraps.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Walk from lowest priority up so the closest requester after ptr_i wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                idx_o   = IW'((int'(ptr_i) + k) % NREQ);
                valid_o = 1'b1;
            end
        end
        gnt_o = valid_o ? NREQ'(1) << idx_o : '0;
    end
endmodule

// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer: shares one VME command/data port among NREQ requesters, one transaction at a time.
// Define VME_CMD_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with err=1 and rdata=16'hDEAD.
module vme_cmd_sequencer
    import vme_cmd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [15:0]          rdata,
    output logic                 busy,
    output logic                 start,
    output logic [31:0]          vme_cmd_reg,
    output logic [31:0]          vme_dat_reg_in,
    input  logic                 vme_cmd_rd,
    input  logic                 vme_dat_wr,
    input  logic [31:0]          vme_dat_reg_out
);
    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, win_q, win_d, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            gnt_vld, rd_q, rd_d, err_q, err_d, tmo;
    logic [15:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

`ifdef VME_CMD_TIMEOUT_EN
    logic [10:0] cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= state_q == WAIT ? cnt_q + 11'd1 : '0;
    assign tmo = state_q == WAIT && cnt_q == 11'(TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (gnt_vld) begin
                win_d   = gnt_idx;
                rd_d    = req_rd[gnt_idx];
                addr_d  = req_addr[{gnt_idx, 4'b0} +: 16];
                wdata_d = req_wdata[{gnt_idx, 4'b0} +: 16];
                err_d   = 1'b0;
                state_d = ISSUE;
            end
            ISSUE: if (vme_cmd_rd) begin
                start   = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (vme_dat_wr) begin
                rdata_d = rd_q ? vme_dat_reg_out[15:0] : rdata_q;
                state_d = DONE;
            end else if (tmo) begin
                rdata_d = TIMEOUT_DATA;
                err_d   = 1'b1;
                state_d = DONE;
            end
            default: begin
                ptr_d   = win_q == IW'(NREQ - 1) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end

    assign ack            = state_q == DONE ? NREQ'(1) << win_q : '0;
    assign err            = state_q == DONE && err_q;
    assign rdata          = rdata_q;
    assign busy           = state_q != IDLE;
    assign vme_cmd_reg    = start ? CMD_MASK | (32'(rd_q) << RD_BIT) | (32'(!rd_q) << WR_BIT) | 32'(addr_q)
                                  : CMD_MASK;
    assign vme_dat_reg_in = start && !rd_q ? {16'h0000, wdata_q} : '0;
endmodule
